// File: rtl/imem_control_decode.sv
// imem_control_decode: 1024x16 write-first instruction RAM feeding a registered opcode
// that is combinationally decoded into the datapath control strobes.
module imem_control_decode #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int OP_MSB = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              wea,
    output logic              alusrc,
    output logic              memtoreg,
    output logic              regdest,
    output logic              regwrite,
    output logic              memread,
    output logic              memwrite,
    output logic              branch
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
    logic [3:0]        ir_op;
    logic              r_type;

    always_ff @(posedge clock) begin
        if (wea) mem[addra] <= dina;
    end

    // Only the opcode field of the instruction register drives any output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ir_op <= 4'h0;
        else       ir_op <= wea ? dina[OP_MSB -: 4] : mem[addra][OP_MSB -: 4];
    end

    always_comb begin
        r_type   = (ir_op >= 4'h1) && (ir_op <= 4'h4);
        regdest  = r_type;
        regwrite = r_type || ir_op == 4'h5 || ir_op == 4'h6;
        alusrc   = ir_op == 4'h5 || ir_op == 4'h6 || ir_op == 4'h7;
        memtoreg = ir_op == 4'h6;
        memread  = ir_op == 4'h6;
        memwrite = ir_op == 4'h7;
        branch   = ir_op == 4'h8 || ir_op == 4'h9;
    end
endmodule

// File: tb/tb_imem_control_decode.sv
// tb_imem_control_decode: scoreboard bench; a driver pushes decoded expectations from a
// reference RAM/opcode table, a negedge monitor pops and compares them.
module tb_imem_control_decode;
    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic        wea;
    logic        alusrc, memtoreg, regdest, regwrite, memread, memwrite, branch;
    logic [6:0]  ctl;
    logic [15:0] ref_mem [0:1023];
    logic [6:0]  expq [$];
    int          checks = 0;
    int          failures = 0;

    imem_control_decode dut (
        .clock(clock), .reset(reset), .addra(addra), .dina(dina), .wea(wea),
        .alusrc(alusrc), .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch(branch)
    );

    always #5 clock = ~clock;
    assign ctl = {alusrc, memtoreg, regdest, regwrite, memread, memwrite, branch};

    // Opcode table order: {as, mr, rd, rw, rd_m, wr_m, br}
    function automatic logic [6:0] decode(input logic [15:0] w);
        logic [3:0] op;
        op = w[15:12];
        if (op >= 4'h1 && op <= 4'h4) return 7'b0011000;
        if (op == 4'h5) return 7'b1001000;
        if (op == 4'h6) return 7'b1101100;
        if (op == 4'h7) return 7'b1000010;
        if (op == 4'h8 || op == 4'h9) return 7'b0000001;
        return 7'b0000000;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [9:0] a, input logic [15:0] d, input logic w);
        logic [15:0] word;
        addra = a; dina = d; wea = w;
        @(posedge clock);
        word = w ? d : ref_mem[a];
        if (w) ref_mem[a] = d;
        expq.push_back(decode(word));
        #1;
    endtask

    always @(negedge clock) begin
        if (expq.size() > 0) begin
            chk("decode", ctl, expq.pop_front());
            chk("rd_wr_excl", {6'b0, memread & memwrite}, 7'b0);
            chk("rw_vs_wr_br", {6'b0, regwrite & (memwrite | branch)}, 7'b0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
        reset = 1'b1; wea = 1'b0; addra = '0; dina = '0;
        repeat (3) begin
            @(negedge clock);
            chk("por", ctl, 7'b0);
        end
        @(posedge clock); #1 reset = 1'b0;
        repeat (3) step(10'd0, 16'h0000, 1'b0);
        step(10'd1, 16'h1123, 1'b1);
        step(10'd2, 16'h6456, 1'b1);
        step(10'd3, 16'h7789, 1'b1);
        step(10'd4, 16'h8001, 1'b1);
        for (int a = 1; a <= 4; a++) step(10'(a), 16'h0000, 1'b0);
        step(10'd5, 16'h5000, 1'b1);
        step(10'd0, 16'h0000, 1'b0);
        step(10'd5, 16'h0000, 1'b0);
        step(10'd6, 16'hF0FF, 1'b1);
        step(10'd6, 16'h0000, 1'b0);
        // Async reset between edges while LW is being decoded
        step(10'd2, 16'h0000, 1'b0);
        @(negedge clock); #1 reset = 1'b1;
        #1 chk("async_reset", ctl, 7'b0);
        #1 reset = 1'b0;
        step(10'd2, 16'h0000, 1'b0);
        // Reset held across a write edge: write lands, decode stays NOP
        @(negedge clock); #1 reset = 1'b1;
        addra = 10'd7; dina = 16'h6ABC; wea = 1'b1;
        @(posedge clock); ref_mem[7] = 16'h6ABC;
        @(negedge clock); chk("reset_write_hold", ctl, 7'b0);
        wea = 1'b0; #1 reset = 1'b0;
        step(10'd7, 16'h0000, 1'b0);
        for (int n = 0; n < 200; n++)
            step(10'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
        wea = 1'b0;
        for (int n = 0; n < 10 && expq.size() > 0; n++) @(negedge clock);
        #1;
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
